// File: rtl/fifo_pack_sync.sv
// -----------------------------------------------------------------------------
// fifo_pack_sync
//
// Single-clock narrow-to-wide packing FIFO. RATIO consecutive accepted input
// words of DIN_W bits are gathered into one DOUT_W = DIN_W*RATIO word. The
// wide word is then stored in a DEPTH-entry FIFO. A flush closes a partially
// filled word early, and its unfilled slots are written as zero.
//
// Parameters
//   DIN_W     width of one input word
//   RATIO     input words per output word (>= 2)
//   DEPTH     storage depth in wide words (power of 2, >= 2)
//   PFULL_TH  prog_full asserts when count >= PFULL_TH (1..DEPTH)
//   MSB_FIRST 0: first input word lands in dout[DIN_W-1:0]
//             1: first input word lands in the top slot
//
// Ports
//   clk        rising-edge clock
//   rstn       asynchronous active-low reset (release synchronised externally)
//   din        narrow input word
//   din_en     din valid this cycle (accepted unless full)
//   flush      close the current partial word
//   rd_en      read request for one wide word (ignored while empty)
//   dout       registered wide output word, holds between reads
//   dout_en    one-cycle pulse, dout carries a freshly read word
//   full       count == DEPTH
//   prog_full  count >= PFULL_TH
//   empty      count == 0
//   count      number of stored wide words
//   overflow   one-cycle pulse, an input word was dropped because of full
// -----------------------------------------------------------------------------
module fifo_pack_sync #(
  parameter int DIN_W     = 4,
  parameter int RATIO     = 4,
  parameter int DEPTH     = 8,
  parameter int PFULL_TH  = 6,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic [DIN_W-1:0]           din,
  input  logic                       din_en,
  input  logic                       flush,
  input  logic                       rd_en,
  output logic [DIN_W*RATIO-1:0]     dout,
  output logic                       dout_en,
  output logic                       full,
  output logic                       prog_full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow
);

  localparam int DOUT_W = DIN_W * RATIO;
  localparam int AW     = $clog2(DEPTH);
  localparam int CW     = AW + 1;
  localparam int PW     = $clog2(RATIO);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [PW-1:0]     pack_cnt;   // number of slots already filled
  logic [DOUT_W-1:0] pack_reg;   // partial wide word, unfilled slots are zero
  logic [AW-1:0]     wptr;
  logic [AW-1:0]     rptr;
  logic [DOUT_W-1:0] mem [DEPTH];

  // ---------------------------------------------------------------------------
  // Datapath decode
  // ---------------------------------------------------------------------------
  logic [PW-1:0]     slot;
  logic              accept;
  logic              last_slot;
  logic              do_flush;
  logic              wr;
  logic              rd;
  logic [DOUT_W-1:0] merged;

  // full gates the write side from the current count only. A read in the
  // same cycle frees space one cycle later, never in the same cycle.
  assign accept    = din_en && !full;
  assign last_slot = (pack_cnt == PW'(RATIO - 1));

  // A flush closes a word if something is pending or is arriving now.
  // While full it is ignored, and the partial word stays in pack_reg.
  assign do_flush  = flush && !full && ((pack_cnt != '0) || accept);
  assign wr        = (accept && last_slot) || do_flush;
  assign rd        = rd_en && !empty;

  // Reversed slot order for MSB_FIRST: the first word goes into the top slot.
  assign slot = MSB_FIRST ? (PW'(RATIO - 1) - pack_cnt) : pack_cnt;

  // The word that would be stored this cycle: the pack register with the
  // incoming din dropped into its slot.
  // NOTE: merged gets a full default before the conditional slot update, so
  // every path assigns it and no latch is inferred.
  always_comb begin
    merged = pack_reg;
    for (int i = 0; i < RATIO; i++) begin
      if (accept && (slot == PW'(i))) begin
        merged[i*DIN_W +: DIN_W] = din;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Control and output registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments, so every register
  // samples pre-edge values and evaluation order inside the block is irrelevant.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pack_cnt <= '0;
      pack_reg <= '0;
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      dout     <= '0;
      dout_en  <= 1'b0;
      overflow <= 1'b0;
    end else begin
      // Packing: a completed or flushed word leaves pack_reg empty for the
      // next word. Otherwise an accepted din is kept in its slot.
      if (wr) begin
        pack_cnt <= '0;
        pack_reg <= '0;
        wptr     <= wptr + 1'b1;
      end else if (accept) begin
        pack_cnt <= pack_cnt + 1'b1;
        pack_reg <= merged;
      end

      // Read side: one-cycle latency, and dout holds when no read happens.
      if (rd) begin
        dout <= mem[rptr];
        rptr <= rptr + 1'b1;
      end
      dout_en <= rd;

      // Occupancy: a write and a read in the same cycle cancel out.
      unique case ({wr, rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      overflow <= din_en && full;
    end
  end

  // ---------------------------------------------------------------------------
  // Storage array
  // ---------------------------------------------------------------------------
  // NOTE: the array has no reset. Clearing the pointers and count already
  // makes every old entry unreachable, and leaving the array unreset lets it
  // map onto plain RAM.
  always_ff @(posedge clk) begin
    if (wr) begin
      mem[wptr] <= merged;
    end
  end

  // ---------------------------------------------------------------------------
  // Status flags, decoded from the count register
  // ---------------------------------------------------------------------------
  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign prog_full = (count >= CW'(PFULL_TH));

endmodule

// File: tb/tb_fifo_pack_sync.sv
// -----------------------------------------------------------------------------
// tb_fifo_pack_sync
//
// Two instances, LSB-first and MSB-first, share one stimulus stream. A
// reference model holds pending narrow words and stored wide words as
// queues. Each issued read pushes the expected wide words into scoreboard
// queues. A monitor pops those queues whenever dout_en is seen. Status
// outputs are compared against the model every cycle.
// -----------------------------------------------------------------------------
module tb_fifo_pack_sync;

  localparam int DIN_W    = 4;
  localparam int RATIO    = 4;
  localparam int DEPTH    = 8;
  localparam int PFULL_TH = 6;
  localparam int DOUT_W   = DIN_W * RATIO;
  localparam int CW       = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic [DIN_W-1:0]  din = '0;
  logic              din_en = 1'b0;
  logic              flush = 1'b0;
  logic              rd_en = 1'b0;

  logic [DOUT_W-1:0] dout,  dout_m;
  logic              dout_en, dout_en_m;
  logic              full, full_m;
  logic              prog_full, prog_full_m;
  logic              empty, empty_m;
  logic [CW-1:0]     count, count_m;
  logic              overflow, overflow_m;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fifo_pack_sync #(
    .DIN_W(DIN_W), .RATIO(RATIO), .DEPTH(DEPTH), .PFULL_TH(PFULL_TH), .MSB_FIRST(1'b0)
  ) u_dut (
    .clk(clk), .rstn(rstn), .din(din), .din_en(din_en), .flush(flush), .rd_en(rd_en),
    .dout(dout), .dout_en(dout_en), .full(full), .prog_full(prog_full),
    .empty(empty), .count(count), .overflow(overflow)
  );

  fifo_pack_sync #(
    .DIN_W(DIN_W), .RATIO(RATIO), .DEPTH(DEPTH), .PFULL_TH(PFULL_TH), .MSB_FIRST(1'b1)
  ) u_dut_msb (
    .clk(clk), .rstn(rstn), .din(din), .din_en(din_en), .flush(flush), .rd_en(rd_en),
    .dout(dout_m), .dout_en(dout_en_m), .full(full_m), .prog_full(prog_full_m),
    .empty(empty_m), .count(count_m), .overflow(overflow_m)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: the FIFO seen as queues of narrow and wide words
  // ---------------------------------------------------------------------------
  int                pend[$];          // accepted narrow words not yet stored
  logic [DOUT_W-1:0] store_l[$];       // stored words, LSB-first packing
  logic [DOUT_W-1:0] store_m[$];       // the same words, MSB-first packing
  logic [DOUT_W-1:0] exp_l[$];         // scoreboard: reads issued, not yet seen
  logic [DOUT_W-1:0] exp_m[$];
  logic [DOUT_W-1:0] last_l = '0, last_m = '0;
  logic              exp_ovf = 1'b0, exp_den = 1'b0;

  function automatic logic [DOUT_W-1:0] pack_words(input bit msb);
    logic [DOUT_W-1:0] w = '0;
    int s;
    for (int k = 0; k < pend.size(); k++) begin
      s = msb ? (RATIO - 1 - k) : k;
      w[s*DIN_W +: DIN_W] = pend[k][DIN_W-1:0];
    end
    return w;
  endfunction

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pend.delete(); store_l.delete(); store_m.delete();
      exp_l.delete(); exp_m.delete();
      last_l = '0; last_m = '0; exp_ovf = 1'b0; exp_den = 1'b0;
    end else begin
      bit was_full, was_empty;
      was_full  = (store_l.size() == DEPTH);
      was_empty = (store_l.size() == 0);
      exp_ovf   = din_en && was_full;
      exp_den   = rd_en && !was_empty;
      if (exp_den) begin
        last_l = store_l.pop_front();
        last_m = store_m.pop_front();
        exp_l.push_back(last_l);
        exp_m.push_back(last_m);
      end
      if (din_en && !was_full) pend.push_back(int'(din));
      if (pend.size() == RATIO || (flush && !was_full && pend.size() > 0)) begin
        store_l.push_back(pack_words(1'b0));
        store_m.push_back(pack_words(1'b1));
        pend.delete();
      end
    end
  end

  // Monitor: consumes the scoreboard whenever a DUT presents a word.
  always @(negedge clk) begin
    if (rstn) begin
      if (dout_en) begin
        if (exp_l.size() == 0) check("unexpected_dout_en_lsb", 1, 0);
        else check("dout_lsb", dout, exp_l.pop_front());
      end
      if (dout_en_m) begin
        if (exp_m.size() == 0) check("unexpected_dout_en_msb", 1, 0);
        else check("dout_msb", dout_m, exp_m.pop_front());
      end
    end
  end

  // Per-cycle status comparison against the model.
  always @(negedge clk) begin
    if (rstn) begin
      int n;
      n = store_l.size();
      check("count",     count, n);
      check("count_msb", count_m, n);
      check("full",      full, n == DEPTH);
      check("empty",     empty, n == 0);
      check("prog_full", prog_full, n >= PFULL_TH);
      check("full_msb",  {full_m, empty_m, prog_full_m},
            {n == DEPTH, n == 0, n >= PFULL_TH});
      check("overflow",  {overflow, overflow_m}, {exp_ovf, exp_ovf});
      check("dout_en",   {dout_en, dout_en_m}, {exp_den, exp_den});
      check("dout_hold", dout, last_l);
      check("dout_hold_msb", dout_m, last_m);
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus: inputs change on the falling edge only
  // ---------------------------------------------------------------------------
  task automatic step(input logic [DIN_W-1:0] d, input logic e, input logic f, input logic r);
    din = d; din_en = e; flush = f; rd_en = r;
    @(negedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 2; i++) step('0, 1'b0, 1'b0, 1'b1);
    step('0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int maxc;
    bit saw_ovf;
    @(negedge clk);
    @(negedge clk);
    // Reset values while held in reset
    check("rst_count", count, 0);
    check("rst_flags", {empty, full, prog_full, dout_en, overflow}, 5'b10000);
    check("rst_dout",  dout, 0);
    rstn = 1'b1;
    @(negedge clk);

    // 1: fill with 32 nibbles, no reads, then one dropped nibble
    for (int i = 1; i <= 32; i++) begin
      step(DIN_W'(i), 1'b1, 1'b0, 1'b0);
      if (i == 4)  check("t1_count_after4", count, 1);
      if (i == 20) check("t1_pfull_low", prog_full, 0);
      if (i == 24) check("t1_pfull_at24", {prog_full, count}, {1'b1, 4'd6});
      if (i == 28) check("t1_not_full", full, 0);
    end
    check("t1_full", {full, count}, {1'b1, 4'd8});
    step(4'hF, 1'b1, 1'b0, 1'b0);
    check("t1_overflow", {overflow, count}, {1'b1, 4'd8});
    step('0, 1'b0, 1'b0, 1'b0);
    check("t1_ovf_pulse", overflow, 0);
    drain();

    // 2: one word, one read, latency 1
    for (int i = 1; i <= 4; i++) step(DIN_W'(i), 1'b1, 1'b0, 1'b0);
    step('0, 1'b0, 1'b0, 1'b1);
    check("t2_dout_lsb", {dout_en, dout}, {1'b1, 16'h4321});
    check("t2_dout_msb", {dout_en_m, dout_m}, {1'b1, 16'h1234});
    step('0, 1'b0, 1'b0, 1'b0);
    check("t2_empty", {empty, dout_en}, 2'b10);

    // 3: partial flush, then a fresh word
    step(4'hA, 1'b1, 1'b0, 1'b0);
    step(4'hB, 1'b1, 1'b0, 1'b0);
    step('0, 1'b0, 1'b1, 1'b0);
    step('0, 1'b0, 1'b0, 1'b1);
    check("t3_flush_lsb", dout, 16'h00BA);
    check("t3_flush_msb", dout_m, 16'hAB00);
    for (int i = 5; i <= 8; i++) step(DIN_W'(i), 1'b1, 1'b0, 1'b0);
    step('0, 1'b0, 1'b0, 1'b1);
    check("t3_next_word", dout, 16'h8765);
    step('0, 1'b0, 1'b1, 1'b0);     // flush with nothing pending: no-op
    check("t3_flush_noop", count, 0);

    // 4: full-rate writes with reads whenever not empty
    maxc = 0; saw_ovf = 0;
    for (int i = 0; i < 100; i++) begin
      step(DIN_W'($urandom), 1'b1, 1'b0, !empty);
      if (int'(count) > maxc) maxc = int'(count);
      if (overflow) saw_ovf = 1;
    end
    check("t4_max_count", maxc <= 2, 1);
    check("t4_no_overflow", saw_ovf, 0);
    drain();

    // 5: read on empty, then a write and read together while full
    step('0, 1'b0, 1'b0, 1'b1);
    check("t5_empty_read", dout_en, 0);
    for (int i = 0; i < 32; i++) step(DIN_W'(i), 1'b1, 1'b0, 1'b0);
    step(4'h9, 1'b1, 1'b0, 1'b1);
    check("t5_full_rw", {overflow, dout_en, count}, {1'b1, 1'b1, 4'd7});
    drain();

    // 6: asynchronous reset with data stored and a word half packed
    for (int i = 1; i <= 16; i++) step(DIN_W'(i), 1'b1, 1'b0, 1'b0);
    step('0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 2; i++) step(4'hC, 1'b1, 1'b0, 1'b0);
    step('0, 1'b0, 1'b0, 1'b0);
    #2 rstn = 1'b0;
    #1;
    check("t6_rst_count", {count, count_m}, 0);
    check("t6_rst_flags", {empty, full, prog_full, dout_en, overflow}, 5'b10000);
    check("t6_rst_dout",  {dout, dout_m}, 0);
    @(negedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);
    for (int i = 1; i <= 4; i++) step(DIN_W'(i), 1'b1, 1'b0, 1'b0);
    check("t6_count_after", count, 1);
    step('0, 1'b0, 1'b0, 1'b1);
    check("t6_no_stale", dout, 16'h4321);
    step('0, 1'b0, 1'b0, 1'b0);

    // 7: random mix of writes, flushes and reads
    for (int i = 0; i < 1500; i++) begin
      step(DIN_W'($urandom), $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 1,
           $urandom_range(0, 9) < 5);
    end
    drain();

    check("scoreboard_empty", exp_l.size() + exp_m.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
